// File: rtl/storage_load_pkg.sv
// Shared definitions for the storage load sequencer: op codes, header layout,
// FSM states and channel ids.
package storage_load_pkg;

   typedef enum logic [1:0] {
      OP_NOP  = 2'b00,
      OP_LOAD = 2'b01,
      OP_RUN  = 2'b10,
      OP_STOP = 2'b11
   } op_e;

   localparam int OP_LSB    = 0;
   localparam int OP_MSB    = 1;
   localparam int CH_LSB    = 4;
   localparam int CH_MSB    = 7;
   localparam int LAYER_LSB = 8;
   localparam int LAYER_MSB = 23;
   localparam int ROWS_LSB  = 24;
   localparam int ROWS_MSB  = 39;
   localparam int HDR_W     = 40;

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_RUN_RST,
      S_RUN_EN,
      S_RUN
   } state_e;

   localparam int CH_WEIGHT = 0;
   localparam int CH_INPUT  = 1;
   localparam int CH_LABEL  = 2;
   localparam int CH_CODE   = 3;

endpackage

// File: rtl/storage_load_header_decode.sv
// Combinational split of a command header beat into its fields.
module storage_load_header_decode
   import storage_load_pkg::*;
#(
   parameter int DATA_W = 48,
   parameter int CH_W   = 4
) (
   input  logic [DATA_W-1:0] i_data,
   output op_e               o_op,
   output logic [CH_W-1:0]   o_channel,
   output logic [15:0]       o_layer,
   output logic [15:0]       o_row_count
);

   // Reserved header bits carry no meaning.
   logic w_unused;
   assign w_unused = ^{i_data[DATA_W-1:HDR_W], i_data[CH_LSB-1:OP_MSB+1]};

   assign o_op        = op_e'(i_data[OP_MSB:OP_LSB]);
   assign o_channel   = CH_W'(i_data[CH_MSB:CH_LSB]);
   assign o_layer     = i_data[LAYER_MSB:LAYER_LSB];
   assign o_row_count = i_data[ROWS_MSB:ROWS_LSB];

endmodule

// File: rtl/storage_load_sequencer.sv
// Turns a header/data beat stream into per-channel storage row writes and
// sequences the locator reset and enables for a RUN command.
module storage_load_sequencer
   import storage_load_pkg::*;
#(
   parameter int LANES  = 3,
   parameter int DATA_W = LANES * 16,
   parameter int NUM_CH = 4,
   parameter int IDX_W  = 32,
   parameter int CH_W   = 4
) (
   input  logic              clk_clk,
   input  logic              reset_reset,
   input  logic [DATA_W-1:0] in_data,
   input  logic              in_valid,
   output logic              in_ready,
   output logic [DATA_W-1:0] wr_data,
   output logic [IDX_W-1:0]  wr_layer_index,
   output logic [IDX_W-1:0]  wr_row_index,
   output logic [NUM_CH-1:0] wr_is_write,
   output logic              locator_reset,
   output logic              code_storage_enable,
   output logic              controller_enable,
   output logic              busy,
   output logic              error,
   output logic [31:0]       rows_written
);

   op_e               w_op;
   logic [CH_W-1:0]   w_channel;
   logic [15:0]       w_layer;
   logic [15:0]       w_row_count;
   logic              w_accept;
   logic              w_ch_ok;
   logic              w_last;
   logic [NUM_CH-1:0] w_onehot;

   state_e            r_state;
   logic [CH_W-1:0]   r_ch;
   logic [IDX_W-1:0]  r_layer;
   logic [15:0]       r_rows;
   logic [15:0]       r_cnt;
   logic [DATA_W-1:0] r_wr_data;
   logic [IDX_W-1:0]  r_wr_layer;
   logic [IDX_W-1:0]  r_wr_row;
   logic [NUM_CH-1:0] r_wr_is_write;
   logic              r_locator_reset;
   logic              r_code_en;
   logic              r_ctrl_en;
   logic              r_error;
   logic [31:0]       r_rows_written;

   storage_load_header_decode #(.DATA_W(DATA_W), .CH_W(CH_W)) u_decode (
      .i_data      (in_data),
      .o_op        (w_op),
      .o_channel   (w_channel),
      .o_layer     (w_layer),
      .o_row_count (w_row_count)
   );

   // The two run-startup states never take a beat.
   assign in_ready = !reset_reset &&
                     (r_state == S_IDLE || r_state == S_LOAD || r_state == S_RUN);
   assign w_accept = in_valid && in_ready;
   assign w_ch_ok  = ({1'b0, r_ch} < (CH_W+1)'(NUM_CH));
   assign w_last   = (r_cnt == r_rows - 16'd1);
   assign w_onehot = NUM_CH'(1) << r_ch;

   always_ff @(posedge clk_clk) begin
      if (reset_reset) begin
         r_state         <= S_IDLE;
         r_ch            <= '0;
         r_layer         <= '0;
         r_rows          <= '0;
         r_cnt           <= '0;
         r_wr_data       <= '0;
         r_wr_layer      <= '0;
         r_wr_row        <= '0;
         r_wr_is_write   <= '0;
         r_locator_reset <= 1'b0;
         r_code_en       <= 1'b0;
         r_ctrl_en       <= 1'b0;
         r_error         <= 1'b0;
         r_rows_written  <= '0;
      end else begin
         r_wr_is_write   <= '0;
         r_locator_reset <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  if (w_op == OP_LOAD && w_row_count != 16'd0) begin
                     r_ch    <= w_channel;
                     r_layer <= IDX_W'(w_layer);
                     r_rows  <= w_row_count;
                     r_cnt   <= '0;
                     r_state <= S_LOAD;
                  end else if (w_op == OP_RUN) begin
                     r_locator_reset <= 1'b1;
                     r_state         <= S_RUN_RST;
                  end
               end
            end
            S_LOAD: begin
               if (w_accept) begin
                  // Bad-channel beats are swallowed so the stream stays aligned.
                  if (w_ch_ok) begin
                     r_wr_data      <= in_data;
                     r_wr_layer     <= r_layer;
                     r_wr_row       <= IDX_W'(r_cnt);
                     r_wr_is_write  <= w_onehot;
                     r_rows_written <= r_rows_written + 32'd1;
                  end else begin
                     r_error <= 1'b1;
                  end
                  r_cnt <= r_cnt + 16'd1;
                  if (w_last) r_state <= S_IDLE;
               end
            end
            S_RUN_RST: begin
               r_code_en <= 1'b1;
               r_state   <= S_RUN_EN;
            end
            S_RUN_EN: begin
               r_ctrl_en <= 1'b1;
               r_state   <= S_RUN;
            end
            S_RUN: begin
               if (w_accept) begin
                  if (w_op == OP_STOP) begin
                     r_code_en <= 1'b0;
                     r_ctrl_en <= 1'b0;
                     r_state   <= S_IDLE;
                  end else if (w_op == OP_LOAD || w_op == OP_RUN) begin
                     r_error <= 1'b1;
                  end
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign wr_data             = r_wr_data;
   assign wr_layer_index      = r_wr_layer;
   assign wr_row_index        = r_wr_row;
   assign wr_is_write         = r_wr_is_write;
   assign locator_reset       = r_locator_reset;
   assign code_storage_enable = r_code_en;
   assign controller_enable   = r_ctrl_en;
   assign busy                = (r_state != S_IDLE);
   assign error               = r_error;
   assign rows_written        = r_rows_written;

endmodule

// File: tb/tb_storage_load_sequencer.sv
// Directed vector bench for storage_load_sequencer: load table plus run and
// reset corner sequences.
module tb_storage_load_sequencer;

   localparam int DW = 48;

   logic          clk = 1'b0;
   logic          rst;
   logic [DW-1:0] din;
   logic          vld;
   logic          rdy;
   logic [DW-1:0] wdata;
   logic [31:0]   wlayer;
   logic [31:0]   wrow;
   logic [3:0]    wr;
   logic          lr, ce, ctl, bsy, err;
   logic [31:0]   nrows;

   int pass_cnt = 0;
   int total    = 0;

   storage_load_sequencer dut (
      .clk_clk             (clk),
      .reset_reset         (rst),
      .in_data             (din),
      .in_valid            (vld),
      .in_ready            (rdy),
      .wr_data             (wdata),
      .wr_layer_index      (wlayer),
      .wr_row_index        (wrow),
      .wr_is_write         (wr),
      .locator_reset       (lr),
      .code_storage_enable (ce),
      .controller_enable   (ctl),
      .busy                (bsy),
      .error               (err),
      .rows_written        (nrows)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic          rst;
      logic          vld;
      logic [DW-1:0] data;
      logic [3:0]    e_wr;
      logic [15:0]   e_row;
      logic [15:0]   e_lay;
      logic [DW-1:0] e_data;
      logic          e_busy;
      logic          e_rdy;
      logic          e_err;
      logic [7:0]    e_rows;
   } vec_t;

   vec_t vt[$];

   function automatic logic [DW-1:0] hdr(input logic [1:0] op, input logic [3:0] ch,
                                         input logic [15:0] lay, input logic [15:0] rows);
      return {8'hA5, rows, lay, ch, 2'b10, op};
   endfunction

   function automatic vec_t mk(input logic r, input logic v, input logic [DW-1:0] d,
                               input logic [3:0] w, input logic [15:0] row, input logic [15:0] lay,
                               input logic [DW-1:0] wd, input logic b, input logic rd,
                               input logic e, input logic [7:0] n);
      vec_t x;
      x.rst = r; x.vld = v; x.data = d; x.e_wr = w; x.e_row = row; x.e_lay = lay;
      x.e_data = wd; x.e_busy = b; x.e_rdy = rd; x.e_err = e; x.e_rows = n;
      return x;
   endfunction

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      else pass_cnt++;
   endtask

   task automatic cyc(input logic r, input logic v, input logic [DW-1:0] d);
      rst = r; vld = v; din = d;
      @(posedge clk);
      @(negedge clk);
   endtask

   localparam logic [1:0] NOP = 2'b00, LOAD = 2'b01, RUN = 2'b10, STOP = 2'b11;
   localparam logic [DW-1:0] A = 48'h1111_2222_3333, B = 48'h4444_5555_6666;
   localparam logic [DW-1:0] C = 48'h7777_8888_9999, D = 48'hDDDD_0000_0ABC;
   localparam logic [DW-1:0] E = 48'hEEEE_1234_5678, F = 48'hFFFF_FFFF_FFFF;
   localparam logic [DW-1:0] G = 48'h0000_0000_0001, H = 48'h8000_0000_0002;

   initial begin
      rst = 1'b1; vld = 1'b0; din = '0;

      vt.push_back(mk(1,0,'0,                 0,0,0,'0, 0,0,0,0));
      vt.push_back(mk(0,0,'0,                 0,0,0,'0, 0,1,0,0));
      vt.push_back(mk(0,1,hdr(LOAD,0,2,3),    0,0,0,'0, 1,1,0,0));
      vt.push_back(mk(0,1,A,                  1,0,2,A,  1,1,0,1));
      vt.push_back(mk(0,1,B,                  1,1,2,B,  1,1,0,2));
      vt.push_back(mk(0,1,C,                  1,2,2,C,  0,1,0,3));
      vt.push_back(mk(0,0,'0,                 0,2,2,C,  0,1,0,3));
      vt.push_back(mk(0,1,hdr(LOAD,3,5,2),    0,2,2,C,  1,1,0,3));
      vt.push_back(mk(0,1,D,                  8,0,5,D,  1,1,0,4));
      vt.push_back(mk(0,0,'0,                 0,0,5,D,  1,1,0,4));
      vt.push_back(mk(0,0,'0,                 0,0,5,D,  1,1,0,4));
      vt.push_back(mk(0,1,E,                  8,1,5,E,  0,1,0,5));
      vt.push_back(mk(0,1,hdr(LOAD,1,9,0),    0,1,5,E,  0,1,0,5));
      vt.push_back(mk(0,0,'0,                 0,1,5,E,  0,1,0,5));
      vt.push_back(mk(0,1,hdr(LOAD,7,3,2),    0,1,5,E,  1,1,0,5));
      vt.push_back(mk(0,1,F,                  0,1,5,E,  1,1,1,5));
      vt.push_back(mk(0,1,G,                  0,1,5,E,  0,1,1,5));
      vt.push_back(mk(0,1,hdr(LOAD,1,4,1),    0,1,5,E,  1,1,1,5));
      vt.push_back(mk(0,1,H,                  2,0,4,H,  0,1,1,6));

      foreach (vt[i]) begin
         cyc(vt[i].rst, vt[i].vld, vt[i].data);
         chk($sformatf("v%0d wr_is_write", i), 64'(wr), 64'(vt[i].e_wr));
         chk($sformatf("v%0d row_index", i), 64'(wrow), 64'(vt[i].e_row));
         chk($sformatf("v%0d layer_index", i), 64'(wlayer), 64'(vt[i].e_lay));
         chk($sformatf("v%0d wr_data", i), 64'(wdata), 64'(vt[i].e_data));
         chk($sformatf("v%0d busy", i), 64'(bsy), 64'(vt[i].e_busy));
         chk($sformatf("v%0d in_ready", i), 64'(rdy), 64'(vt[i].e_rdy));
         chk($sformatf("v%0d error", i), 64'(err), 64'(vt[i].e_err));
         chk($sformatf("v%0d rows_written", i), 64'(nrows), 64'(vt[i].e_rows));
         chk($sformatf("v%0d run_outs", i), 64'({lr, ce, ctl}), 64'(0));
      end

      // Run sequence and illegal command while running.
      cyc(1, 0, '0);
      chk("run reset error", 64'(err), 64'(0));
      cyc(0, 1, hdr(RUN, 0, 0, 0));
      chk("t+1 locator_reset", 64'({lr, rdy, ce, ctl}), 64'(4'b1000));
      cyc(0, 1, hdr(STOP, 0, 0, 0));
      chk("t+2 code_en", 64'({lr, rdy, ce, ctl, bsy}), 64'(5'b00101));
      cyc(0, 0, '0);
      chk("t+3 ctrl_en", 64'({lr, rdy, ce, ctl, bsy}), 64'(5'b01111));
      cyc(0, 1, hdr(NOP, 0, 0, 0));
      chk("run nop ignored", 64'({err, ce, ctl, bsy}), 64'(4'b0111));
      cyc(0, 1, hdr(LOAD, 0, 1, 2));
      chk("run illegal load", 64'({err, ce, ctl, bsy, wr}), 64'(8'b1111_0000));
      cyc(0, 1, hdr(STOP, 0, 0, 0));
      chk("stop drops enables", 64'({ce, ctl, bsy, wr}), 64'(7'b000_0000));
      chk("stop err sticky", 64'(err), 64'(1));

      // Reset in the middle of a 4-row load.
      cyc(1, 0, '0);
      cyc(0, 1, hdr(LOAD, 2, 7, 4));
      cyc(0, 1, 48'h0123_4567_89AB);
      chk("mid beat1 strobe", 64'({wr, nrows[7:0]}), 64'({4'b0100, 8'd1}));
      chk("mid beat1 data", 64'(wdata), 64'(48'h0123_4567_89AB));
      cyc(1, 1, 48'h0000_0000_0055);
      chk("mid rst outs", 64'({wr, lr, ce, ctl, bsy, err, rdy}), 64'(0));
      chk("mid rst wr_data", 64'(wdata), 64'(0));
      chk("mid rst idx", 64'({wlayer, wrow}), 64'(0));
      chk("mid rst rows", 64'(nrows), 64'(0));
      cyc(0, 1, hdr(LOAD, 0, 1, 1));
      chk("post rst header", 64'({bsy, wr, rdy}), 64'({1'b1, 4'b0000, 1'b1}));
      cyc(0, 1, 48'hCAFE_0000_BEEF);
      chk("post rst strobe", 64'({wr, bsy, nrows[7:0]}), 64'({4'b0001, 1'b0, 8'd1}));
      chk("post rst data", 64'(wdata), 64'(48'hCAFE_0000_BEEF));
      chk("post rst idx", 64'({wlayer, wrow}), 64'({32'd1, 32'd0}));

      $display("%0d/%0d checks passed", pass_cnt, total);
      $finish;
   end

endmodule

// File: doc/storage_load_sequencer.md
Name: storage_load_sequencer

Overview:
- Synthesizable replacement for the file-driven storage preload used in data_path simulation.
- Accepts a valid/ready stream of command headers and data beats, and fans the beats out as row writes to NUM_CH storages (weight, input, label, code, ...).
- On a RUN command, pulses the matrix storage locator reset, then raises code-storage and controller enables in the fixed order the data path requires.
- Sits between the host/DMA stream and the data_path storage write interfaces.

Parameters:
- LANES, 3, number of 16-bit fixed-point lanes per beat.
- DATA_W, LANES*16, beat and row width in bits. Must be ≥ 40.
- NUM_CH, 4, number of target storages. Channel order: 0 weight, 1 input, 2 label, 3 code.
- IDX_W, 32, width of the layer and row index outputs.
- CH_W, 4, width of the channel-id field. Requires NUM_CH ≤ 2^CH_W.

Ports:
- clk_clk  in  1  single clock; all logic rising-edge.
- reset_reset  in  1  synchronous, active-high reset.
- in_data  in  DATA_W  header or data beat.
- in_valid  in  1  beat valid.
- in_ready  out  1  beat accepted when in_valid && in_ready.
- wr_data  out  DATA_W  row data, shared by all channels. The code channel uses bits [11:0].
- wr_layer_index  out  IDX_W  layer index taken from the header.
- wr_row_index  out  IDX_W  row index, 0..row_count-1. Used as write_line for the code channel.
- wr_is_write  out  NUM_CH  one-hot write strobe.
- locator_reset  out  1  one-cycle pulse to matrix_storage_locator.
- code_storage_enable  out  1  code storage fetch enable.
- controller_enable  out  1  controller enable.
- busy  out  1  high in any state other than IDLE.
- error  out  1  sticky protocol-error flag.
- rows_written  out  32  count of strobed writes since reset.

Behaviour:
- Header fields:
  - [1:0] op: 00 NOP, 01 LOAD, 10 RUN, 11 STOP.
  - [7:4] channel.
  - [23:8] layer index, zero-extended to IDX_W.
  - [39:24] row_count.
  - All other bits are ignored.
- Reset: all outputs 0, state IDLE, counters 0. This takes priority over every other event in the same cycle, including mid-LOAD and mid-RUN; partial loads are abandoned.
- States: IDLE, LOAD, RUN_RST, RUN_EN, RUN.
- IDLE: in_ready=1. On an accepted header:
  - NOP: stay in IDLE.
  - LOAD with row_count=0: stay in IDLE, no write.
  - LOAD with row_count>0: latch channel, layer and row_count, clear the row counter, go to LOAD.
  - RUN: go to RUN_RST.
  - STOP: no effect.
- LOAD: in_ready=1. Each accepted beat is a data beat, never a header.
  - Next cycle: wr_data = beat, wr_row_index = counter, wr_layer_index = latched layer, wr_is_write[channel]=1 for exactly one cycle.
  - Write latency is 1 cycle after acceptance. Back-to-back beats give back-to-back strobes.
  - After the row_count-th beat, return to IDLE. The next header may be accepted in the cycle right after the last beat.
  - in_valid low: hold state, no strobe.
- Invalid channel (channel ≥ NUM_CH): beats are still consumed, no strobe is issued, and error is set.
- RUN_RST: in_ready=0; locator_reset=1 for this cycle only. Next state RUN_EN.
- RUN_EN: code_storage_enable=1, controller_enable=0. Next state RUN.
- RUN: code_storage_enable=1, controller_enable=1, in_ready=1.
  - STOP: both enables drop the following cycle; return to IDLE.
  - NOP: ignored.
  - LOAD or RUN: dropped and error set. No data beats are consumed for a dropped LOAD.
- rows_written increments by 1 for each strobe and wraps at 2^32.
- error clears only on reset.
- Outputs in wr_* hold their last value when no strobe is active. Only wr_is_write is qualified.

Decomposition:
- Package storage_load_pkg holds:
  - op codes (OP_NOP, OP_LOAD, OP_RUN, OP_STOP);
  - header field bit positions;
  - state enum;
  - channel constants (CH_WEIGHT=0, CH_INPUT=1, CH_LABEL=2, CH_CODE=3).
- One sub-module, storage_load_header_decode: a purely combinational split of in_data into op/channel/layer/row_count.
- The FSM, counters and output registers stay in the top module.

Test Plan:
- Load weights: LOAD ch0, layer 2, rows 3, then beats A,B,C back-to-back.
  - Expect 3 consecutive strobes wr_is_write=0001 with row_index 0,1,2, layer 2, data A,B,C.
  - Expect rows_written=3.
- Gapped and zero-length loads: LOAD ch3, rows 2, with in_valid low for 2 cycles between beats.
  - Expect exactly 2 strobes on bit 3, no strobe in the gaps.
  - A following LOAD with rows 0 gives no strobe and busy returns to 0 the next cycle.
- Invalid channel: LOAD ch7, rows 2, plus 2 beats.
  - Expect no strobes, error=1, state IDLE afterwards.
  - A following valid LOAD ch1, rows 1 strobes normally.
- Run sequence: RUN header accepted at cycle t.
  - Expect locator_reset=1 only at t+1, code_storage_enable from t+2, controller_enable from t+3, in_ready=0 at t+1.
  - STOP accepted at cycle s gives both enables 0 at s+1.
- Illegal command during run: a LOAD header accepted in RUN gives error=1 and enables stay high.
- Reset mid-load: assert reset_reset after beat 1 of a 4-row load.
  - Next cycle all outputs are 0, state IDLE.
  - The next beat is treated as a header.
